// File: rtl/dh_pkg.sv
// -----------------------------------------------------------------------------
// dh_pkg
// Shared types and constants for the light-gun shot sequencer.
//   shot_state_t       : sequencer FSM states
//   AMMO_W             : width of the ammo counter
//   CNT_W              : width of the shared frame counter (covers 1..63 frames)
//   *_DEF              : default parameter values used by the sequencer
// -----------------------------------------------------------------------------
package dh_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ARM      = 3'd1,
      S_BLACK    = 3'd2,
      S_TARGET   = 3'd3,
      S_RESULT   = 3'd4,
      S_COOLDOWN = 3'd5
   } shot_state_t;

   localparam int AMMO_W              = 4;
   localparam int CNT_W               = 6;

   localparam int TARGET_FRAMES_DEF   = 1;
   localparam int COOLDOWN_FRAMES_DEF = 15;
   localparam int AMMO_MAX_DEF        = 3;
   localparam int DET_MIN_CYCLES_DEF  = 8;

endpackage : dh_pkg

// File: rtl/photo_filter.sv
// -----------------------------------------------------------------------------
// photo_filter
// Turns the synchronised photodetector level into a "light seen" indication.
// Build option: DH_PHOTO_FILTER_EN
//   undefined : any single high cycle of photo counts as light (pass-through)
//   defined   : light is reported only once photo has stayed high for
//               DET_MIN_CYCLES consecutive cycles; the indication therefore
//               lags photo by one clock.
// Ports:
//   i_clk         pixel clock
//   i_rst_n       asynchronous active-low reset
//   i_photo       photodetector level, 1 = light
//   o_light_seen  light indication used by the sequencer
// -----------------------------------------------------------------------------
module photo_filter
   import dh_pkg::*;
#(
   parameter int DET_MIN_CYCLES = DET_MIN_CYCLES_DEF
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_photo,
   output logic o_light_seen
);

`ifdef DH_PHOTO_FILTER_EN

   localparam int RUN_W = $clog2(DET_MIN_CYCLES + 1);

   logic [RUN_W-1:0] r_run;

   // Run-length of consecutive high photo cycles, saturating at the threshold
   // so a long exposure keeps reporting light without wrapping.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_run <= '0;
      end else if (!i_photo) begin
         r_run <= '0;
      end else if (r_run != RUN_W'(DET_MIN_CYCLES)) begin
         r_run <= r_run + RUN_W'(1);
      end
   end

   assign o_light_seen = (r_run == RUN_W'(DET_MIN_CYCLES));

`else

   logic w_unused;

   assign o_light_seen = i_photo;
   assign w_unused     = ^{i_clk, i_rst_n, 32'(DET_MIN_CYCLES)};

`endif

endmodule : photo_filter

// File: rtl/gun_shot_sequencer.sv
// -----------------------------------------------------------------------------
// gun_shot_sequencer
// Sequences one light-gun shot: a forced all-black frame, then
// TARGET_FRAMES highlight frames, sampling the photodetector in each to decide
// hit or miss. Owns the ammo count and drives the renderer blank/highlight
// controls. Pixel-clock domain.
// Build option: DH_PHOTO_FILTER_EN (glitch filter inside photo_filter).
// Ports:
//   i_clk, i_rst_n     pixel clock, asynchronous active-low reset
//   i_frame_start      one-cycle pulse at start of vertical blanking
//   i_trigger          one-cycle debounced trigger press
//   i_reload           one-cycle reload press
//   i_photo            synchronised photodetector level
//   o_force_black      renderer draws the whole frame black
//   o_show_target      renderer draws targets as white boxes on black
//   o_hit / o_miss     one-cycle verdict pulses (miss also covers dry fire)
//   o_busy             shot in progress or cooldown
//   o_ammo             rounds remaining
// -----------------------------------------------------------------------------
module gun_shot_sequencer
   import dh_pkg::*;
#(
   parameter int TARGET_FRAMES   = TARGET_FRAMES_DEF,
   parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF,
   parameter int AMMO_MAX        = AMMO_MAX_DEF,
   parameter int DET_MIN_CYCLES  = DET_MIN_CYCLES_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_frame_start,
   input  logic              i_trigger,
   input  logic              i_reload,
   input  logic              i_photo,
   output logic              o_force_black,
   output logic              o_show_target,
   output logic              o_hit,
   output logic              o_miss,
   output logic              o_busy,
   output logic [AMMO_W-1:0] o_ammo
);

   shot_state_t       r_state;
   shot_state_t       w_next_state;
   logic [AMMO_W-1:0] r_ammo;
   logic [CNT_W-1:0]  r_frame_cnt;
   logic [CNT_W-1:0]  w_frame_cnt_inc;
   logic              r_light_flag;
   logic              r_hit_flag;
   logic              w_light;
   logic              w_fire;
   logic              w_dry_fire;
   logic              w_reload_ok;
   logic              w_force_black_d;
   logic              w_show_target_d;
   logic              w_busy_d;
   logic              w_hit_d;
   logic              w_miss_d;

   photo_filter #(
      .DET_MIN_CYCLES (DET_MIN_CYCLES)
   ) u_photo_filter (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_photo      (i_photo),
      .o_light_seen (w_light)
   );

   // Reload has priority over a trigger in the same cycle.
   assign w_reload_ok     = i_reload && ((r_state == S_IDLE) || (r_state == S_COOLDOWN));
   assign w_fire          = (r_state == S_IDLE) && i_trigger && !i_reload && (r_ammo != '0);
   assign w_dry_fire      = (r_state == S_IDLE) && i_trigger && !i_reload && (r_ammo == '0);
   assign w_frame_cnt_inc = r_frame_cnt + CNT_W'(1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // A frame_start coinciding with light still belongs to the frame that is
   // ending, so the black-frame decision looks at the live light input too.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_fire) w_next_state = S_ARM;
         end
         S_ARM: begin
            if (i_frame_start) w_next_state = S_BLACK;
         end
         S_BLACK: begin
            if (i_frame_start) begin
               w_next_state = (r_light_flag || w_light) ? S_RESULT : S_TARGET;
            end
         end
         S_TARGET: begin
            if (i_frame_start && (w_frame_cnt_inc == CNT_W'(TARGET_FRAMES))) begin
               w_next_state = S_RESULT;
            end
         end
         S_RESULT: begin
            w_next_state = S_COOLDOWN;
         end
         S_COOLDOWN: begin
            if (i_frame_start && (w_frame_cnt_inc == CNT_W'(COOLDOWN_FRAMES))) begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Renderer controls follow the next state, so they flip on the edge that
   // consumes frame_start and never in the middle of a frame.
   always_comb begin
      w_force_black_d = (w_next_state == S_BLACK);
      w_show_target_d = (w_next_state == S_TARGET);
      w_busy_d        = (w_next_state != S_IDLE);
      w_hit_d         = (r_state == S_RESULT) && r_hit_flag;
      w_miss_d        = ((r_state == S_RESULT) && !r_hit_flag) || w_dry_fire;
   end

   // Registered outputs, ammo, per-shot flags and the shared frame counter.
   // The counter is cleared on every state change so TARGET and COOLDOWN each
   // start counting from zero.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_force_black <= 1'b0;
         o_show_target <= 1'b0;
         o_hit         <= 1'b0;
         o_miss        <= 1'b0;
         o_busy        <= 1'b0;
         r_ammo        <= AMMO_W'(AMMO_MAX);
         r_frame_cnt   <= '0;
         r_light_flag  <= 1'b0;
         r_hit_flag    <= 1'b0;
      end else begin
         o_force_black <= w_force_black_d;
         o_show_target <= w_show_target_d;
         o_hit         <= w_hit_d;
         o_miss        <= w_miss_d;
         o_busy        <= w_busy_d;

         if (w_reload_ok) begin
            r_ammo <= AMMO_W'(AMMO_MAX);
         end else if (w_fire) begin
            r_ammo <= r_ammo - AMMO_W'(1);
         end

         if (r_state != w_next_state) begin
            r_frame_cnt <= '0;
         end else if (i_frame_start && ((r_state == S_TARGET) || (r_state == S_COOLDOWN))) begin
            r_frame_cnt <= w_frame_cnt_inc;
         end

         if ((r_state == S_ARM) && i_frame_start) begin
            r_light_flag <= 1'b0;
            r_hit_flag   <= 1'b0;
         end else begin
            if ((r_state == S_BLACK) && w_light)  r_light_flag <= 1'b1;
            if ((r_state == S_TARGET) && w_light) r_hit_flag   <= 1'b1;
         end
      end
   end

   assign o_ammo = r_ammo;

endmodule : gun_shot_sequencer

// File: tb/tb_gun_shot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gun_shot_sequencer
// Drives whole shots against gun_shot_sequencer with frame_start every FL
// cycles and randomized photodetector pulses, and predicts each shot's timing
// and verdict from the frame arithmetic of the shot sequence.
// -----------------------------------------------------------------------------
module tb_gun_shot_sequencer;

   localparam int TF  = 1;
   localparam int CD  = 15;
   localparam int AM  = 3;
   localparam int DMC = 8;
   localparam int FL  = 40;
`ifdef DH_PHOTO_FILTER_EN
   localparam int THR = DMC;
`else
   localparam int THR = 1;
`endif

   logic       clk = 1'b0;
   logic       rstN;
   logic       frameStart;
   logic       trigger;
   logic       reload;
   logic       photo;
   logic       forceBlack;
   logic       showTarget;
   logic       hit;
   logic       miss;
   logic       busy;
   logic [3:0] ammo;

   int cyc;
   int photoLo, photoHi, photoLo2, photoHi2;
   int fbCount, stCount, hitCount, missCount, busyHighCount;
   int hitCyc, missCyc, busyFallCyc;
   int ammoModel;
   int compareCount;
   int failCount;

   gun_shot_sequencer #(
      .TARGET_FRAMES   (TF),
      .COOLDOWN_FRAMES (CD),
      .AMMO_MAX        (AM),
      .DET_MIN_CYCLES  (DMC)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rstN),
      .i_frame_start (frameStart),
      .i_trigger     (trigger),
      .i_reload      (reload),
      .i_photo       (photo),
      .o_force_black (forceBlack),
      .o_show_target (showTarget),
      .o_hit         (hit),
      .o_miss        (miss),
      .o_busy        (busy),
      .o_ammo        (ammo)
   );

   // Free-running pixel clock.
   always #5 clk = ~clk;

   // Single comparison point for every check in the bench.
   task automatic checkOutput(input string tag, input int actual, input int expected);
      compareCount++;
      if (actual != expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic clearStats();
      fbCount = 0; stCount = 0; hitCount = 0; missCount = 0; busyHighCount = 0;
      hitCyc = -1; missCyc = -1; busyFallCyc = -1;
   endtask

   // Drives one clock cycle: frame_start every FL cycles, photo from the
   // planned windows, then samples outputs #1 after the edge as the next cycle.
   task automatic applyStimulus(input logic trig, input logic rel);
      trigger    = trig;
      reload     = rel;
      frameStart = (cyc % FL == 0);
      photo      = ((cyc >= photoLo) && (cyc <= photoHi)) ||
                   ((cyc >= photoLo2) && (cyc <= photoHi2));
      @(posedge clk);
      #1;
      cyc++;
      trigger = 1'b0;
      reload  = 1'b0;
      fbCount += int'(forceBlack);
      stCount += int'(showTarget);
      busyHighCount += int'(busy);
      if (hit)  begin hitCount++;  hitCyc  = cyc; end
      if (miss) begin missCount++; missCyc = cyc; end
      if ((busyFallCyc < 0) && !busy) busyFallCyc = cyc;
   endtask

   // One complete shot. blackLen/targetLen are photo pulse lengths (0 = dark)
   // placed well inside the black and first target frame.
   task automatic fireShot(input int blackLen, input int targetLen, input bit cdTrig);
      int tTrig, f1, fR, expBusyFall, cdT, resCyc;
      bit lightB, lightT, expHit;
      repeat ($urandom_range(0, FL - 1)) applyStimulus(1'b0, 1'b0);
      tTrig = cyc;
      f1    = (tTrig / FL + 1) * FL;
      photoLo = -1; photoHi = -2; photoLo2 = -1; photoHi2 = -2;
      if (blackLen > 0) begin
         photoLo = f1 + 1 + $urandom_range(2, FL - blackLen - 6);
         photoHi = photoLo + blackLen - 1;
      end
      if (targetLen > 0) begin
         photoLo2 = f1 + FL + 1 + $urandom_range(2, FL - targetLen - 6);
         photoHi2 = photoLo2 + targetLen - 1;
      end
      lightB      = (blackLen >= THR);
      lightT      = (targetLen >= THR);
      expHit      = !lightB && lightT;
      fR          = lightB ? (f1 + FL) : (f1 + FL * (1 + TF));
      expBusyFall = fR + CD * FL + 1;
      cdT         = fR + FL + 7;
      clearStats();
      applyStimulus(1'b1, 1'b0);
      ammoModel = ammoModel - 1;
      checkOutput("ammo_after_trigger", int'(ammo), ammoModel);
      while ((cyc < expBusyFall + 3) && (cyc < tTrig + 5000))
         applyStimulus(cdTrig && (cyc == cdT), 1'b0);
      resCyc = expHit ? hitCyc : missCyc;
      checkOutput("force_black_cycles", fbCount, FL);
      checkOutput("show_target_cycles", stCount, lightB ? 0 : TF * FL);
      checkOutput("hit_pulses", hitCount, int'(expHit));
      checkOutput("miss_pulses", missCount, int'(!expHit));
      checkOutput("result_cycle", resCyc, fR + 2);
      checkOutput("busy_fall_cycle", busyFallCyc, expBusyFall);
      checkOutput("ammo_after_shot", int'(ammo), ammoModel);
      photoLo = -1; photoHi = -2; photoLo2 = -1; photoHi2 = -2;
   endtask

   task automatic dryFire();
      int tTrig;
      clearStats();
      tTrig = cyc;
      applyStimulus(1'b1, 1'b0);
      repeat (2 * FL) applyStimulus(1'b0, 1'b0);
      checkOutput("dry_miss_pulses", missCount, 1);
      checkOutput("dry_miss_cycle", missCyc, tTrig + 1);
      checkOutput("dry_force_black", fbCount, 0);
      checkOutput("dry_busy_cycles", busyHighCount, 0);
      checkOutput("dry_ammo", int'(ammo), 0);
   endtask

   task automatic reloadTest(input bit withTrig);
      clearStats();
      applyStimulus(withTrig, 1'b1);
      ammoModel = AM;
      checkOutput("ammo_after_reload", int'(ammo), AM);
      if (withTrig) begin
         repeat (2 * FL) applyStimulus(1'b0, 1'b0);
         checkOutput("reload_trig_busy", busyHighCount, 0);
         checkOutput("reload_trig_miss", missCount, 0);
         checkOutput("reload_trig_fb", fbCount, 0);
         checkOutput("reload_trig_ammo", int'(ammo), AM);
      end
   endtask

   initial begin
      int f1;
      compareCount = 0; failCount = 0;
      cyc = 0; ammoModel = AM;
      photoLo = -1; photoHi = -2; photoLo2 = -1; photoHi2 = -2;
      rstN = 1'b0; frameStart = 1'b0; trigger = 1'b0; reload = 1'b0; photo = 1'b0;
      #12;
      checkOutput("rst_force_black", int'(forceBlack), 0);
      checkOutput("rst_show_target", int'(showTarget), 0);
      checkOutput("rst_hit", int'(hit), 0);
      checkOutput("rst_miss", int'(miss), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_ammo", int'(ammo), AM);
      @(negedge clk);
      rstN = 1'b1;

      // Directed shots from the test plan.
      fireShot(0, 0, 1'b0);
      fireShot(0, 20, 1'b1);
      fireShot(10, 0, 1'b0);
      dryFire();
      reloadTest(1'b0);
      reloadTest(1'b1);
      fireShot(0, 5, 1'b0);
      fireShot(0, 8, 1'b0);

      // Randomized shots.
      repeat (5) begin
         if (ammoModel == 0) reloadTest(1'b0);
         fireShot(($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : 0,
                  ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20),
                  1'($urandom_range(0, 1)));
      end

      // Reset in the middle of the target frame.
      if (ammoModel == 0) reloadTest(1'b0);
      f1 = (cyc / FL + 1) * FL;
      applyStimulus(1'b1, 1'b0);
      while ((cyc < f1 + FL + 10) && (cyc < 100000)) applyStimulus(1'b0, 1'b0);
      checkOutput("target_before_reset", int'(showTarget), 1);
      checkOutput("busy_before_reset", int'(busy), 1);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("midrst_force_black", int'(forceBlack), 0);
      checkOutput("midrst_show_target", int'(showTarget), 0);
      checkOutput("midrst_busy", int'(busy), 0);
      checkOutput("midrst_hit", int'(hit), 0);
      checkOutput("midrst_miss", int'(miss), 0);
      checkOutput("midrst_ammo", int'(ammo), AM);
      @(negedge clk);
      rstN = 1'b1;
      clearStats();
      repeat (2 * FL) applyStimulus(1'b0, 1'b0);
      checkOutput("post_reset_busy", busyHighCount, 0);
      checkOutput("post_reset_target", stCount, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule : tb_gun_shot_sequencer
